// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline-control definitions: strobe levels, register address codes,
// FSM state encodings and the default MEM wait limit.
`timescale 1ns/1ps
package hazard_ctrl_pkg;

    localparam logic PAUSE_ENABLE = 1'b1;
    localparam logic FLUSH_ENABLE = 1'b1;

    localparam int REG_ADDR_BUS = 4;

    // Codes 0-7 are the general-purpose registers; these follow them.
    localparam logic [REG_ADDR_BUS-1:0] REG_SP = 4'd8;
    localparam logic [REG_ADDR_BUS-1:0] REG_IH = 4'd9;
    localparam logic [REG_ADDR_BUS-1:0] REG_RA = 4'd10;
    localparam logic [REG_ADDR_BUS-1:0] REG_T  = 4'd11;

    localparam int WAIT_MAX_DEFAULT = 15;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use detection and priority encoding of the pause/flush
// strobes: freeze, then jump, then load-use, then structural contention.
`timescale 1ns/1ps
module hazard_detect
    import hazard_ctrl_pkg::*;
(
    input  logic                    freeze,
    input  logic                    ex_jump_taken,
    input  logic                    mem_inst_conflict,
    input  logic [REG_ADDR_BUS-1:0] id_rs_a,
    input  logic                    id_rs_a_used,
    input  logic [REG_ADDR_BUS-1:0] id_rs_b,
    input  logic                    id_rs_b_used,
    input  logic [REG_ADDR_BUS-1:0] ie_wb_addr,
    input  logic                    ie_is_load,
    output logic                    pc_PAUSE,
    output logic                    ii_PAUSE,
    output logic                    ie_PAUSE,
    output logic                    em_PAUSE,
    output logic                    ii_FLUSH,
    output logic                    ie_FLUSH
);

    logic load_use;

    assign load_use = ie_is_load &
                      ((id_rs_a_used & (id_rs_a == ie_wb_addr)) |
                       (id_rs_b_used & (id_rs_b == ie_wb_addr)));

    always_comb begin
        pc_PAUSE = ~PAUSE_ENABLE;
        ii_PAUSE = ~PAUSE_ENABLE;
        ie_PAUSE = ~PAUSE_ENABLE;
        em_PAUSE = ~PAUSE_ENABLE;
        ii_FLUSH = ~FLUSH_ENABLE;
        ie_FLUSH = ~FLUSH_ENABLE;
        if (freeze) begin
            pc_PAUSE = PAUSE_ENABLE;
            ii_PAUSE = PAUSE_ENABLE;
            ie_PAUSE = PAUSE_ENABLE;
            em_PAUSE = PAUSE_ENABLE;
        end else if (ex_jump_taken) begin
            ii_FLUSH = FLUSH_ENABLE;
            ie_FLUSH = FLUSH_ENABLE;
        end else if (load_use) begin
            // IF/ID holds, so a fetch lost to a concurrent conflict is harmless
            pc_PAUSE = PAUSE_ENABLE;
            ii_PAUSE = PAUSE_ENABLE;
            ie_FLUSH = FLUSH_ENABLE;
        end else if (mem_inst_conflict) begin
            pc_PAUSE = PAUSE_ENABLE;
            ii_FLUSH = FLUSH_ENABLE;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: MEM wait FSM with timeout guard, sticky timeout
// flag and saturating stall counter around the combinational hazard_detect.
`timescale 1ns/1ps
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int WAIT_MAX = WAIT_MAX_DEFAULT,
    parameter int CNT_W    = 16
) (
    input  logic                    clk_50MHz,
    input  logic                    rst,
    input  logic [REG_ADDR_BUS-1:0] id_rs_a,
    input  logic                    id_rs_a_used,
    input  logic [REG_ADDR_BUS-1:0] id_rs_b,
    input  logic                    id_rs_b_used,
    input  logic [REG_ADDR_BUS-1:0] ie_wb_addr,
    input  logic                    ie_is_load,
    input  logic                    ex_jump_taken,
    input  logic                    mem_inst_conflict,
    input  logic                    mem_req,
    input  logic                    mem_ready,
    output logic                    pc_PAUSE,
    output logic                    ii_PAUSE,
    output logic                    ie_PAUSE,
    output logic                    em_PAUSE,
    output logic                    ii_FLUSH,
    output logic                    ie_FLUSH,
    output logic                    mem_timeout,
    output logic [CNT_W-1:0]        stall_cnt
);

    localparam logic [3:0] WAIT_LAST = 4'(WAIT_MAX - 1);

    state_t     state;
    state_t     next_state;
    logic [3:0] wait_cnt;
    logic       freeze;
    logic       timeout_exit;

    // A ready (or the forced timeout exit) in MEM_WAIT lets the pipeline advance
    // that same cycle, mirroring a same-cycle ready in RUN.
    always_comb begin
        next_state   = state;
        freeze       = 1'b0;
        timeout_exit = 1'b0;
        case (state)
            RUN: begin
                if (mem_req && !mem_ready) begin
                    next_state = MEM_WAIT;
                    freeze     = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (mem_ready) begin
                    next_state = RUN;
                end else if (wait_cnt == WAIT_LAST) begin
                    next_state   = RUN;
                    timeout_exit = 1'b1;
                end else begin
                    freeze = 1'b1;
                end
            end
            default: next_state = RUN;
        endcase
    end

    always_ff @(posedge clk_50MHz or negedge rst) begin
        if (!rst) begin
            state    <= RUN;
            wait_cnt <= 4'd0;
        end else begin
            state    <= next_state;
            wait_cnt <= (state == MEM_WAIT) ? wait_cnt + 4'd1 : 4'd0;
        end
    end

    always_ff @(posedge clk_50MHz or negedge rst) begin
        if (!rst) begin
            mem_timeout <= 1'b0;
            stall_cnt   <= '0;
        end else begin
            if (timeout_exit) begin
                mem_timeout <= 1'b1;
            end
            if ((pc_PAUSE == PAUSE_ENABLE) && (stall_cnt != {CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

    hazard_detect u_detect (
        .freeze            (freeze),
        .ex_jump_taken     (ex_jump_taken),
        .mem_inst_conflict (mem_inst_conflict),
        .id_rs_a           (id_rs_a),
        .id_rs_a_used      (id_rs_a_used),
        .id_rs_b           (id_rs_b),
        .id_rs_b_used      (id_rs_b_used),
        .ie_wb_addr        (ie_wb_addr),
        .ie_is_load        (ie_is_load),
        .pc_PAUSE          (pc_PAUSE),
        .ii_PAUSE          (ii_PAUSE),
        .ie_PAUSE          (ie_PAUSE),
        .em_PAUSE          (em_PAUSE),
        .ii_FLUSH          (ii_FLUSH),
        .ie_FLUSH          (ie_FLUSH)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl; strobe vector order is
// {pc_PAUSE, ii_PAUSE, ie_PAUSE, em_PAUSE, ii_FLUSH, ie_FLUSH}.
`timescale 1ns/1ps
module tb_hazard_ctrl;
    import hazard_ctrl_pkg::*;

    logic        clk_50MHz = 1'b0;
    logic        rst;
    logic [3:0]  id_rs_a, id_rs_b, ie_wb_addr;
    logic        id_rs_a_used, id_rs_b_used, ie_is_load;
    logic        ex_jump_taken, mem_inst_conflict, mem_req, mem_ready;
    logic        pc_PAUSE, ii_PAUSE, ie_PAUSE, em_PAUSE, ii_FLUSH, ie_FLUSH;
    logic        mem_timeout;
    logic [15:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    always #10 clk_50MHz = ~clk_50MHz;

    hazard_ctrl #(.WAIT_MAX(15), .CNT_W(16)) dut (
        .clk_50MHz         (clk_50MHz),
        .rst               (rst),
        .id_rs_a           (id_rs_a),
        .id_rs_a_used      (id_rs_a_used),
        .id_rs_b           (id_rs_b),
        .id_rs_b_used      (id_rs_b_used),
        .ie_wb_addr        (ie_wb_addr),
        .ie_is_load        (ie_is_load),
        .ex_jump_taken     (ex_jump_taken),
        .mem_inst_conflict (mem_inst_conflict),
        .mem_req           (mem_req),
        .mem_ready         (mem_ready),
        .pc_PAUSE          (pc_PAUSE),
        .ii_PAUSE          (ii_PAUSE),
        .ie_PAUSE          (ie_PAUSE),
        .em_PAUSE          (em_PAUSE),
        .ii_FLUSH          (ii_FLUSH),
        .ie_FLUSH          (ie_FLUSH),
        .mem_timeout       (mem_timeout),
        .stall_cnt         (stall_cnt)
    );

    // Drives one cycle's inputs and settles mid-cycle, well away from any edge.
    task automatic applyStimulus(input logic load, input logic [3:0] wb,
                                 input logic [3:0] rs_a, input logic a_used,
                                 input logic [3:0] rs_b, input logic b_used,
                                 input logic jump, input logic conflict,
                                 input logic req, input logic ready);
        ie_is_load        = load;
        ie_wb_addr        = wb;
        id_rs_a           = rs_a;
        id_rs_a_used      = a_used;
        id_rs_b           = rs_b;
        id_rs_b_used      = b_used;
        ex_jump_taken     = jump;
        mem_inst_conflict = conflict;
        mem_req           = req;
        mem_ready         = ready;
        #4;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk_50MHz);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [5:0] expected);
        logic [5:0] observed;
        observed = {pc_PAUSE, ii_PAUSE, ie_PAUSE, em_PAUSE, ii_FLUSH, ie_FLUSH};
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
        end
    endtask

    task automatic checkValue(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    initial begin
        rst = 1'b0;
        idle();
        checkOutput("reset_strobes", 6'b000000);
        checkValue("reset_stall_cnt", int'(stall_cnt), 0);
        checkValue("reset_timeout", int'(mem_timeout), 0);
        #11;
        rst = 1'b1;
        tick();

        idle();
        checkOutput("idle", 6'b000000);

        // Load-use on rs_a: one-cycle pause plus bubble
        tick();
        applyStimulus(1'b1, 4'd3, 4'd3, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("load_use_a", 6'b110001);
        tick();
        idle();
        checkOutput("load_use_a_after", 6'b000000);
        checkValue("stall_after_load_use", int'(stall_cnt), 1);

        // Address matches but rs_a is not read
        tick();
        applyStimulus(1'b1, 4'd3, 4'd3, 1'b0, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("load_unused_src", 6'b000000);

        // Load-use on rs_b with a special-register code
        applyStimulus(1'b1, REG_SP, 4'd1, 1'b1, REG_SP, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("load_use_b_sp", 6'b110001);
        tick();
        idle();
        checkValue("stall_after_load_use_b", int'(stall_cnt), 2);

        // Non-load writer never stalls
        applyStimulus(1'b0, 4'd3, 4'd3, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("non_load_match", 6'b000000);

        // Jump beats load-use
        tick();
        applyStimulus(1'b1, 4'd3, 4'd3, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("jump_over_load_use", 6'b000011);
        tick();
        idle();
        checkValue("stall_after_jump", int'(stall_cnt), 2);

        // Structural contention alone
        applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("structural", 6'b100010);
        tick();
        idle();
        checkValue("stall_after_structural", int'(stall_cnt), 3);

        // Structural plus load-use resolves to the load-use action
        applyStimulus(1'b1, 4'd6, 4'd6, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("structural_and_load_use", 6'b110001);
        tick();
        idle();
        checkValue("stall_after_combo", int'(stall_cnt), 4);

        // Same-cycle ready: no stall at all
        applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        checkOutput("mem_same_cycle_ready", 6'b000000);
        tick();
        idle();
        checkValue("stall_after_fast_mem", int'(stall_cnt), 4);

        // MEM wait: three freeze cycles, a pending jump held until release
        applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("mem_wait_c1", 6'b111100);
        tick();
        idle();
        checkOutput("mem_wait_c2", 6'b111100);
        tick();
        applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("mem_wait_c3_jump_held", 6'b111100);
        tick();
        applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        checkOutput("mem_ready_jump_serviced", 6'b000011);
        tick();
        idle();
        checkOutput("mem_after_ready", 6'b000000);
        checkValue("mem_no_timeout", int'(mem_timeout), 0);
        checkValue("stall_after_mem_wait", int'(stall_cnt), 7);

        // Timeout: 15 freeze cycles, then forced release and sticky flag
        applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 15; i++) begin
            checkOutput($sformatf("timeout_freeze_%0d", i), 6'b111100);
            tick();
            idle();
        end
        checkOutput("timeout_release", 6'b000000);
        checkValue("timeout_not_yet", int'(mem_timeout), 0);
        tick();
        idle();
        checkValue("timeout_set", int'(mem_timeout), 1);
        checkOutput("timeout_run", 6'b000000);
        checkValue("stall_after_timeout", int'(stall_cnt), 22);
        tick();
        tick();
        idle();
        checkValue("timeout_sticky", int'(mem_timeout), 1);

        // Async reset during the second MEM_WAIT cycle
        applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        idle();
        tick();
        idle();
        checkOutput("pre_reset_frozen", 6'b111100);
        rst = 1'b0;
        #1;
        checkOutput("async_reset_strobes", 6'b000000);
        checkValue("async_reset_stall_cnt", int'(stall_cnt), 0);
        checkValue("async_reset_timeout", int'(mem_timeout), 0);
        #2;
        rst = 1'b1;
        tick();
        idle();
        checkOutput("post_reset_idle", 6'b000000);
        checkValue("post_reset_stall_cnt", int'(stall_cnt), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline control unit that produces the per-stage PAUSE and FLUSH (bubble) strobes consumed by the PC, IF/ID, ID/EXE and EXE/MEM pipeline registers.
- Detects load-use data hazards (ID vs EXE), taken jumps resolved in EXE, and IF/MEM contention on the shared instruction SRAM.
- Freezes the whole pipeline while a multi-cycle MEM access (SRAM/UART) waits for its ready handshake, with a timeout guard.
- Keeps a saturating stall counter for debug.

Parameters:
WAIT_MAX, 15, max cycles spent in MEM_WAIT before forced release
CNT_W, 16, width of stall statistics counter

Ports:
clk_50MHz  in  1  system clock
rst  in  1  asynchronous, active-low reset
id_rs_a  in  4  ID-stage source A register address (GPR 0-7, SP/IH/RA/T codes from package)
id_rs_a_used  in  1  ID instruction reads rs_a
id_rs_b  in  4  ID-stage source B register address
id_rs_b_used  in  1  ID instruction reads rs_b
ie_wb_addr  in  4  EXE-stage destination register address
ie_is_load  in  1  EXE instruction is a RAM read with register writeback
ex_jump_taken  in  1  EXE resolved a taken branch/jump this cycle
mem_inst_conflict  in  1  MEM stage accesses the instruction SRAM this cycle
mem_req  in  1  MEM stage starts a multi-cycle access
mem_ready  in  1  memory controller completes access
pc_PAUSE  out  1  hold PC
ii_PAUSE  out  1  hold IF/ID
ie_PAUSE  out  1  hold ID/EXE
em_PAUSE  out  1  hold EXE/MEM
ii_FLUSH  out  1  load NOP into IF/ID
ie_FLUSH  out  1  load NOP into ID/EXE
mem_timeout  out  1  sticky: a MEM access hit WAIT_MAX
stall_cnt  out  CNT_W  saturating count of cycles with pc_PAUSE asserted

Behaviour:
- All strobes active-high (PAUSE_ENABLE = 1). Strobes are combinational from FSM state plus current inputs, effective at the same clock edge (zero latency). mem_timeout and stall_cnt are registered.
- Reset (rst low, async): state=RUN, wait_cnt=0, mem_timeout=0, stall_cnt=0. Strobes evaluate to 0 because reset forces RUN and the inputs are idle.
- FSM states: RUN, MEM_WAIT.
  - RUN -> MEM_WAIT when mem_req=1 and mem_ready=0. A same-cycle ready completes the access with no stall.
  - MEM_WAIT -> RUN when mem_ready=1, or when wait_cnt==WAIT_MAX-1. The timeout exit sets mem_timeout, which stays set until reset.
  - wait_cnt clears on entry to MEM_WAIT, increments each MEM_WAIT cycle, and is 4 bits wide (WAIT_MAX<=16).
- Hazard terms:
  - load_use = ie_is_load & ((id_rs_a_used & id_rs_a==ie_wb_addr) | (id_rs_b_used & id_rs_b==ie_wb_addr)).
- Priority, highest first. Exactly one action applies per cycle; all strobes not listed are 0.
  1. Freeze: in MEM_WAIT, or RUN with mem_req=1 and mem_ready=0. Assert pc/ii/ie/em_PAUSE, no flush. A pending jump is held by the frozen EXE stage and is serviced after release.
  2. Jump: ex_jump_taken. Assert ii_FLUSH and ie_FLUSH, no pause. A load_use on the wrong path is discarded.
  3. Load-use: assert pc_PAUSE, ii_PAUSE and ie_FLUSH for exactly one cycle. The load leaves EXE next cycle, so load_use drops by itself.
  4. Structural: mem_inst_conflict. Assert pc_PAUSE and ii_FLUSH.
  - Load-use and structural in the same cycle resolve to the load-use action. IF/ID holds its instruction, so the lost fetch is harmless.
- stall_cnt increments on every clock with pc_PAUSE=1 and saturates at all-ones.
- Reset mid-MEM_WAIT returns to RUN immediately. The timeout flag clears.

Decomposition:
- Shared package/define.v: PAUSE_ENABLE/FLUSH_ENABLE levels, REG_ADDR_BUS width, special register codes (SP, IH, RA, T), FSM state encodings, WAIT_MAX default.
- One natural sub-module: hazard_detect (pure combinational load_use/priority encoder). The FSM, counters and flag stay in hazard_ctrl.

Test Plan:
- Load-use: ie_is_load=1, ie_wb_addr=3, id_rs_a=3, id_rs_a_used=1 for one cycle -> pc_PAUSE=ii_PAUSE=ie_FLUSH=1 that cycle only, stall_cnt 0->1.
- Jump vs load-use: ex_jump_taken=1 together with the load-use setup above -> ii_FLUSH=ie_FLUSH=1, pc_PAUSE=0, stall_cnt unchanged.
- MEM wait: mem_req=1, mem_ready held 0 for 3 cycles then 1 -> all four PAUSE=1 for 3 cycles, 0 in the ready cycle, state RUN, mem_timeout=0.
- Timeout: mem_req=1, mem_ready never asserted -> exactly 15 freeze cycles, then mem_timeout=1 and sticky, PAUSE released.
- Structural: mem_inst_conflict=1 with no other hazard -> pc_PAUSE=ii_FLUSH=1, ie_PAUSE=ie_FLUSH=0. Adding a simultaneous load-use -> pc_PAUSE=ii_PAUSE=ie_FLUSH=1, ii_FLUSH=0.
- Async reset asserted in the 2nd MEM_WAIT cycle -> all strobes 0 with no clock edge, stall_cnt=0, mem_timeout=0.
